// File: rtl/ddr1_pkg.sv
// Shared encodings for the DDR1 device model: command bus, mode fields,
// error causes and the data-path state machine.
package ddr1_pkg;
    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_LMR   = 4'b0000;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_NOP   = 4'b0111;

    localparam logic [2:0] CL_2 = 3'b010;
    localparam logic [2:0] CL_3 = 3'b011;
    localparam logic [2:0] BL_2 = 3'b001;
    localparam logic [2:0] BL_4 = 3'b010;
    localparam logic [2:0] BL_8 = 3'b011;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CLOSED   = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd2;
    localparam logic [2:0] ERR_MODE     = 3'd3;
    localparam logic [2:0] ERR_REF_OPEN = 3'd4;
    localparam logic [2:0] ERR_WR_IN_RD = 3'd5;
    localparam logic [2:0] ERR_NO_MODE  = 3'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_RD_LAT, ST_RD_BURST, ST_WR_BURST} state_e;
endpackage

// File: rtl/ddr1_device_model_if.sv
// Command/address bus and status flags between a DDR1 controller and the device.
interface ddr1_device_model_if;
    logic        cke;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [7:0]  dm;
    logic        mode_valid;
    logic [3:0]  bank_open;
    logic        err;
    logic [2:0]  err_code;

    modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm,
                    input  mode_valid, bank_open, err, err_code);
    modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dm,
                    output mode_valid, bank_open, err, err_code);
endinterface

// File: rtl/ddr1_dev_array.sv
// Device storage: synchronous read port (registered data) and byte-enabled write port.
module ddr1_dev_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [1:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);
    logic [15:0] r_mem [2**AW];
    logic [15:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && i_be[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
        if (i_we && i_be[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/ddr1_device_model.sv
// Behavioural-but-synthesizable DDR1 x16 device: mode register, per-bank open rows,
// CL/BL-timed bursts with wrapped columns, and protocol-violation reporting.
module ddr1_device_model
    import ddr1_pkg::*;
#(
    parameter int ROW_BITS = 2,
    parameter int COL_BITS = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    ddr1_device_model_if.slave   bus,
    inout  wire  [63:0]          dq,
    inout  wire  [7:0]           dqs
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;

    state_e                          r_state;
    logic [2:0]                      r_cl, r_bl;
    logic                            r_mode_valid;
    logic [3:0]                      r_bank_open;
    logic [3:0][ROW_BITS-1:0]        r_row;
    logic [1:0]                      r_bank;
    logic [ROW_BITS-1:0]             r_brow;
    logic [COL_BITS-1:0]             r_col;
    logic [2:0]                      r_beat;
    logic [1:0]                      r_lat;
    logic                            r_dq_oe;
    logic                            r_err;
    logic [2:0]                      r_err_code;

    logic [3:0]          w_cmd;
    logic                w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_mode_ok, w_rd_pend;
    logic                w_err, w_we;
    logic [2:0]          w_code, w_last;
    logic [COL_BITS-1:0] w_col, w_mask;
    logic [AW-1:0]       w_waddr, w_raddr;
    logic [15:0]         w_rdata;
    logic                w_unused;

    // Low log2(BL) column bits wrap inside the burst; upper bits stay fixed.
    function automatic logic [COL_BITS-1:0] col_at(input logic [COL_BITS-1:0] base,
                                                   input logic [2:0] k,
                                                   input logic [COL_BITS-1:0] mask);
        return (base & ~mask) | ((base + COL_BITS'(k)) & mask);
    endfunction

    assign w_cmd     = {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
    assign w_act     = bus.cke && (w_cmd == CMD_ACT);
    assign w_rd      = bus.cke && (w_cmd == CMD_READ);
    assign w_wr      = bus.cke && (w_cmd == CMD_WRITE);
    assign w_pre     = bus.cke && (w_cmd == CMD_PRE);
    assign w_ref     = bus.cke && (w_cmd == CMD_REF);
    assign w_lmr     = bus.cke && (w_cmd == CMD_LMR);
    assign w_col     = bus.addr[COL_BITS-1:0];
    assign w_rd_pend = (r_state == ST_RD_LAT) || (r_state == ST_RD_BURST);
    assign w_mode_ok = (bus.addr[6:4] == CL_2 || bus.addr[6:4] == CL_3) &&
                       (bus.addr[2:0] == BL_2 || bus.addr[2:0] == BL_4 || bus.addr[2:0] == BL_8);
    assign w_last    = (r_bl == BL_2) ? 3'd1 : (r_bl == BL_8) ? 3'd7 : 3'd3;
    assign w_mask    = COL_BITS'(w_last);

    // Later assignments win, so the lowest code is reported on coincidence.
    always_comb begin
        w_code = ERR_NONE;
        if ((w_act || w_rd || w_wr) && !r_mode_valid) w_code = ERR_NO_MODE;
        if (w_wr && w_rd_pend)                         w_code = ERR_WR_IN_RD;
        if (w_ref && |r_bank_open)                     w_code = ERR_REF_OPEN;
        if (w_lmr && bus.ba == 2'd0 && !w_mode_ok)     w_code = ERR_MODE;
        if (w_act && r_bank_open[bus.ba])              w_code = ERR_ACT_OPEN;
        if ((w_rd || w_wr) && !r_bank_open[bus.ba])    w_code = ERR_CLOSED;
    end
    assign w_err = (w_code != ERR_NONE);

    // Write beat 0 lands on the command edge; a READ cuts off a running write burst.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        if (w_wr && !w_err) begin
            w_we    = 1'b1;
            w_waddr = {bus.ba, r_row[bus.ba], w_col};
        end else if (r_state == ST_WR_BURST && !(w_rd && !w_err)) begin
            w_we    = 1'b1;
            w_waddr = {r_bank, r_brow, col_at(r_col, r_beat, w_mask)};
        end
    end
    assign w_raddr = {r_bank, r_brow, col_at(r_col, r_beat, w_mask)};

    ddr1_dev_array #(.AW(AW)) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (~bus.dm[1:0]),
        .i_waddr (w_waddr),
        .i_wdata (dq[15:0]),
        .i_re    (r_state == ST_RD_BURST),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cl         <= CL_2;
            r_bl         <= BL_4;
            r_mode_valid <= 1'b0;
            r_bank_open  <= '0;
            r_bank       <= '0;
            r_brow       <= '0;
            r_col        <= '0;
            r_beat       <= '0;
            r_lat        <= '0;
            r_dq_oe      <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_err      <= w_err;
            r_err_code <= w_code;
            r_dq_oe    <= (r_state == ST_RD_BURST);
            case (r_state)
                ST_RD_LAT: begin
                    if (r_lat <= 2'd1) r_state <= ST_RD_BURST;
                    else               r_lat   <= r_lat - 2'd1;
                end
                ST_RD_BURST, ST_WR_BURST: begin
                    if (r_beat == w_last) r_state <= ST_IDLE;
                    else                  r_beat  <= r_beat + 3'd1;
                end
                default: ;
            endcase
            if (!w_err) begin
                if (w_rd || w_wr) begin
                    r_bank <= bus.ba;
                    r_brow <= r_row[bus.ba];
                    r_col  <= w_col;
                end
                if (w_rd) begin
                    r_beat  <= 3'd0;
                    r_lat   <= 2'(r_cl - 3'd2);
                    r_state <= (r_cl == CL_3) ? ST_RD_LAT : ST_RD_BURST;
                end
                if (w_wr) begin
                    r_beat  <= 3'd1;
                    r_state <= ST_WR_BURST;
                end
                if (w_act) begin
                    r_bank_open[bus.ba] <= 1'b1;
                    r_row[bus.ba]       <= bus.addr[ROW_BITS-1:0];
                end
                if (w_pre) begin
                    if (bus.addr[10]) r_bank_open         <= '0;
                    else              r_bank_open[bus.ba] <= 1'b0;
                end
                if (w_lmr && bus.ba == 2'd0) begin
                    r_cl         <= bus.addr[6:4];
                    r_bl         <= bus.addr[2:0];
                    r_mode_valid <= 1'b1;
                end
            end
        end
    end

    assign dq  = r_dq_oe ? {48'h0, w_rdata} : 64'bz;
    assign dqs = r_dq_oe ? 8'hFF : 8'bz;

    assign bus.mode_valid = r_mode_valid;
    assign bus.bank_open  = r_bank_open;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;

    assign w_unused = ^{bus.addr, bus.dm[7:2], dq[63:16]};
endmodule

// File: tb/tb_ddr1_device_model.sv
// Directed bench for ddr1_device_model: mode/bank bookkeeping, burst timing,
// column wrap, byte masks, violation codes and mid-burst reset.
module tb_ddr1_device_model;
    import ddr1_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_dq_oe = 1'b0;
    logic [15:0] tb_dq = '0;
    wire  [63:0] dq;
    wire  [7:0]  dqs;
    int          n_chk = 0;
    int          n_err = 0;

    ddr1_device_model_if bus ();

    ddr1_device_model #(.ROW_BITS(2), .COL_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .dq  (dq),
        .dqs (dqs)
    );

    assign dq = tb_dq_oe ? {48'h0, tb_dq} : 64'bz;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = c;
        bus.ba   = b;
        bus.addr = a;
    endtask

    // Present a command for one edge; returns at the falling edge after it.
    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a);
        set_cmd(c, b, a);
        @(negedge clk);
        set_cmd(CMD_NOP, 2'd0, 13'd0);
    endtask

    task automatic wr4(input logic [1:0] b, input logic [12:0] a,
                       input logic [3:0][15:0] d, input logic [3:0][1:0] m);
        set_cmd(CMD_WRITE, b, a);
        tb_dq_oe = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tb_dq  = d[k];
            bus.dm = {6'h0, m[k]};
            @(negedge clk);
            set_cmd(CMD_NOP, 2'd0, 13'd0);
        end
        tb_dq_oe = 1'b0;
        bus.dm   = '0;
    endtask

    // From the falling edge after a READ: `pre` idle cycles, then 4 beats, then release.
    task automatic burst4(input string tag, input int pre, input logic [3:0][15:0] exp);
        repeat (pre) @(negedge clk);
        chk({tag, "_lat_oe"}, 64'(dut.r_dq_oe), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk({tag, "_beat"}, 64'(dq[15:0]), 64'(exp[k]));
            if (k == 0) chk({tag, "_dqs"}, 64'(dqs), 64'hFF);
        end
        @(negedge clk);
        chk({tag, "_end_oe"}, 64'(dut.r_dq_oe), 64'd0);
    endtask

    initial begin
        bus.cke = 1'b1;
        bus.dm  = '0;
        set_cmd(CMD_NOP, 2'd0, 13'd0);
        repeat (3) @(negedge clk);
        chk("rst_mode_valid", 64'(bus.mode_valid), 64'd0);
        chk("rst_bank_open",  64'(bus.bank_open),  64'd0);
        chk("rst_err",        64'(bus.err),        64'd0);
        chk("rst_err_code",   64'(bus.err_code),   64'd0);
        chk("rst_dq_oe",      64'(dut.r_dq_oe),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(CMD_ACT, 2'd1, 13'd2);
        chk("nomode_err",  64'(bus.err),       64'd1);
        chk("nomode_code", 64'(bus.err_code),  64'(ERR_NO_MODE));
        chk("nomode_bank", 64'(bus.bank_open), 64'd0);
        @(negedge clk);
        chk("err_one_cycle", 64'(bus.err), 64'd0);

        issue(CMD_LMR, 2'd0, 13'h022);
        chk("lmr_mode_valid", 64'(bus.mode_valid), 64'd1);
        issue(CMD_ACT, 2'd1, 13'd2);
        chk("act_bank_open", 64'(bus.bank_open), 64'b0010);

        wr4(2'd1, 13'd4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, '0);
        issue(CMD_READ, 2'd1, 13'd4);
        burst4("rd_cl2", 0, {16'h4444, 16'h3333, 16'h2222, 16'h1111});

        wr4(2'd1, 13'd8, {16'h0, 16'h0, 16'h0, 16'h1234}, '0);
        wr4(2'd1, 13'd8, {16'h5555, 16'h5555, 16'h5555, 16'hABCD},
            {2'b11, 2'b11, 2'b11, 2'b10});
        issue(CMD_READ, 2'd1, 13'd8);
        burst4("rd_dm", 0, {16'h0, 16'h0, 16'h0, 16'h12CD});

        issue(CMD_LMR, 2'd0, 13'h032);
        issue(CMD_READ, 2'd1, 13'd6);
        burst4("rd_cl3_wrap", 1, {16'h2222, 16'h1111, 16'h4444, 16'h3333});

        issue(CMD_READ, 2'd1, 13'd4);
        issue(CMD_READ, 2'd1, 13'd6);
        chk("trunc_err", 64'(bus.err), 64'd0);
        burst4("rd_trunc", 1, {16'h2222, 16'h1111, 16'h4444, 16'h3333});

        issue(CMD_READ, 2'd1, 13'd4);
        issue(CMD_WRITE, 2'd1, 13'd4);
        chk("wr_in_rd_err",  64'(bus.err),      64'd1);
        chk("wr_in_rd_code", 64'(bus.err_code), 64'(ERR_WR_IN_RD));
        burst4("rd_after_wr", 0, {16'h4444, 16'h3333, 16'h2222, 16'h1111});

        issue(CMD_READ, 2'd2, 13'd0);
        chk("closed_err",  64'(bus.err),      64'd1);
        chk("closed_code", 64'(bus.err_code), 64'(ERR_CLOSED));
        repeat (3) begin
            @(negedge clk);
            chk("closed_dq_z", 64'(dut.r_dq_oe), 64'd0);
        end

        issue(CMD_ACT, 2'd1, 13'd3);
        chk("act_open_code", 64'(bus.err_code), 64'(ERR_ACT_OPEN));
        issue(CMD_LMR, 2'd0, 13'h052);
        chk("lmr_bad_code", 64'(bus.err_code), 64'(ERR_MODE));
        chk("lmr_bad_mode", 64'(bus.mode_valid), 64'd1);

        issue(CMD_ACT, 2'd0, 13'd1);
        issue(CMD_ACT, 2'd3, 13'd0);
        chk("three_open", 64'(bus.bank_open), 64'b1011);
        issue(CMD_REF, 2'd0, 13'd0);
        chk("ref_open_code", 64'(bus.err_code), 64'(ERR_REF_OPEN));
        issue(CMD_PRE, 2'd0, 13'h400);
        chk("pre_all", 64'(bus.bank_open), 64'd0);
        issue(CMD_REF, 2'd0, 13'd0);
        chk("ref_ok_err", 64'(bus.err), 64'd0);

        issue(CMD_LMR, 2'd0, 13'h022);
        issue(CMD_ACT, 2'd1, 13'd2);
        issue(CMD_READ, 2'd1, 13'd4);
        @(negedge clk);
        chk("pre_rst_beat0", 64'(dq[15:0]), 64'h1111);
        @(negedge clk);
        chk("pre_rst_beat1", 64'(dq[15:0]), 64'h2222);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_dq_z",  64'(dut.r_dq_oe),    64'd0);
        chk("rst_mid_mode",  64'(bus.mode_valid), 64'd0);
        chk("rst_mid_banks", 64'(bus.bank_open),  64'd0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
